// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg: shared state, opcode and one-hot encodings for the datapath control FSM
package dp_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOADT, S_CALC, S_WB, S_DONE} state_t;
  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_XOR = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;
  localparam logic [2:0] SR_IN = 3'b001;
  localparam logic [2:0] SR_ALU = 3'b010;
  localparam logic [2:0] SR_TMP = 3'b100;
  localparam logic [2:0] TSEL_ALU = 3'b001;
  localparam logic [2:0] TSEL_OUT = 3'b010;
  localparam logic [2:0] TSEL_B = 3'b100;
  localparam logic [1:0] ALU_XOR = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_SHL = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;
  // rs=00 selects the constant-zero operand, so no B-mux line is raised
  function automatic logic [2:0] bsel_dec(input logic [1:0] rs);
    return rs == 2'd1 ? 3'b001 : rs == 2'd2 ? 3'b010 : rs == 2'd3 ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/dp_ctrl_fsm_if.sv
// dp_ctrl_fsm_if: instruction handshake and datapath control lines of the control FSM
interface dp_ctrl_fsm_if #(parameter int OPW = 3, parameter int REGW = 2);
  logic start;
  logic [OPW-1:0] opcode;
  logic [REGW-1:0] rd;
  logic [REGW-1:0] rs;
  logic [2:0] sr;
  logic [REGW-1:0] Rn;
  logic w;
  logic [1:0] aluop;
  logic lt;
  logic [2:0] tsel;
  logic [2:0] bsel;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, opcode, rd, rs,
    input sr, Rn, w, aluop, lt, tsel, bsel, busy, done, err
  );
  modport slave (
    input start, opcode, rd, rs,
    output sr, Rn, w, aluop, lt, tsel, bsel, busy, done, err
  );
endinterface

// File: rtl/dp_ctrl_decode.sv
// dp_ctrl_decode: opcode classification into legality, sequencing needs and ALU operation
module dp_ctrl_decode
  import dp_ctrl_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] opcode,
  output logic           legal,
  output logic           needs_loadt,
  output logic           needs_calc,
  output logic [1:0]     aluop
);
  always_comb begin
    legal = opcode inside {OP_LDI, OP_XOR, OP_AND, OP_SHL, OP_MOV};
    needs_calc = opcode inside {OP_XOR, OP_AND, OP_SHL};
    needs_loadt = needs_calc || opcode == OP_MOV;
    aluop = opcode == OP_AND ? ALU_AND : opcode == OP_SHL ? ALU_SHL : opcode == OP_MOV ? ALU_PASS : ALU_XOR;
  end
endmodule

// File: rtl/dp_ctrl_fsm.sv
// dp_ctrl_fsm: sequences register-file/ALU control lines for one latched instruction
module dp_ctrl_fsm
  import dp_ctrl_pkg::*;
#(
  parameter int OPW = 3,
  parameter int REGW = 2
) (
  input logic clk,
  input logic rst_n,
  dp_ctrl_fsm_if.slave bus
);
  typedef struct packed {
    logic [2:0]      sr;
    logic [REGW-1:0] rn;
    logic            w;
    logic [1:0]      aluop;
    logic            lt;
    logic [2:0]      tsel;
    logic [2:0]      bsel;
    logic            busy;
    logic            done;
    logic            err;
  } ctrl_t;
  state_t state_q, state_n;
  logic [OPW-1:0] op_q, op_n;
  logic [REGW-1:0] rd_q, rd_n, rs_q, rs_n;
  logic take, legal, needs_loadt, needs_calc, alu_phase;
  logic [1:0] alu_op;
  ctrl_t ctrl_q, ctrl_n;
  // Outputs are computed from the fields as they will be after this edge
  assign take = state_q == S_IDLE && bus.start;
  assign op_n = take ? bus.opcode : op_q;
  assign rd_n = take ? bus.rd : rd_q;
  assign rs_n = take ? bus.rs : rs_q;
  dp_ctrl_decode #(.OPW(OPW)) u_decode (
    .opcode      (op_n),
    .legal       (legal),
    .needs_loadt (needs_loadt),
    .needs_calc  (needs_calc),
    .aluop       (alu_op)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      ctrl_q <= '0;
    end else begin
      state_q <= state_n;
      op_q <= op_n;
      rd_q <= rd_n;
      rs_q <= rs_n;
      ctrl_q <= ctrl_n;
    end
  end
  always_comb begin
    state_n = S_IDLE;
    case (state_q)
      S_IDLE:  state_n = !bus.start ? S_IDLE : !legal ? S_DONE : needs_loadt ? S_LOADT : S_WB;
      S_LOADT: state_n = needs_calc ? S_CALC : S_WB;
      S_CALC:  state_n = S_WB;
      S_WB:    state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // aluop/bsel stay up through WB because the registered ALU recomputes every cycle
  always_comb begin
    ctrl_n = '0;
    alu_phase = needs_calc && (state_n == S_CALC || state_n == S_WB);
    ctrl_n.lt = state_n == S_LOADT;
    ctrl_n.tsel = !ctrl_n.lt ? 3'b000 : needs_calc ? TSEL_OUT : TSEL_B;
    ctrl_n.w = state_n == S_WB;
    ctrl_n.rn = ctrl_n.w ? rd_n : '0;
    ctrl_n.sr = !ctrl_n.w ? 3'b000 : needs_calc ? SR_ALU : needs_loadt ? SR_TMP : SR_IN;
    ctrl_n.aluop = alu_phase ? alu_op : ALU_XOR;
    ctrl_n.bsel = (alu_phase && op_n != OP_SHL) || (ctrl_n.lt && !needs_calc) ? bsel_dec(rs_n) : 3'b000;
    ctrl_n.busy = state_n inside {S_LOADT, S_CALC, S_WB};
    ctrl_n.done = state_n == S_DONE;
    ctrl_n.err = ctrl_n.done && !legal;
  end
  assign bus.sr = ctrl_q.sr;
  assign bus.Rn = ctrl_q.rn;
  assign bus.w = ctrl_q.w;
  assign bus.aluop = ctrl_q.aluop;
  assign bus.lt = ctrl_q.lt;
  assign bus.tsel = ctrl_q.tsel;
  assign bus.bsel = ctrl_q.bsel;
  assign bus.busy = ctrl_q.busy;
  assign bus.done = ctrl_q.done;
  assign bus.err = ctrl_q.err;
endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// tb_dp_ctrl_fsm: control FSM driving a behavioural datapath, checked against an instruction-level model
module tb_dp_ctrl_fsm;
  import dp_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dp_ctrl_fsm_if bus ();
  dp_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] din;
  logic [7:0] r_m [4];
  logic [7:0] tmp_m, alu_m, b_m;
  logic [7:0] ref_r [4];
  always_comb b_m = bus.bsel == 3'b001 ? r_m[1] : bus.bsel == 3'b010 ? r_m[2] : bus.bsel == 3'b100 ? r_m[3] : 8'h00;
  always @(posedge clk) begin
    case (bus.aluop)
      2'b00: alu_m <= tmp_m ^ b_m;
      2'b01: alu_m <= tmp_m & b_m;
      2'b10: alu_m <= {tmp_m[6:0], 1'b0};
      default: alu_m <= b_m;
    endcase
    if (bus.lt) tmp_m <= bus.tsel == 3'b001 ? alu_m : bus.tsel == 3'b010 ? r_m[0] : b_m;
    if (bus.w) r_m[bus.Rn] <= bus.sr == 3'b001 ? din : bus.sr == 3'b010 ? alu_m : tmp_m;
  end
  int errs = 0;
  int checks = 0;
  int lat, nw, nlt, nbusy, nerr, oh_bad;
  logic [2:0] t_sr [16];
  logic [2:0] t_tsel [16];
  logic [2:0] t_bsel [16];
  logic [1:0] t_alu [16];
  logic [1:0] t_rn [16];
  logic t_w [16];
  logic t_lt [16];
  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] d;
    int lat;
    int nw;
    int err;
    logic [7:0] val;
  } vec_t;
  vec_t tbl [11];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [2:0] op);
    return op == 3'd0 ? 2 : op <= 3'd3 ? 4 : op == 3'd4 ? 3 : 1;
  endfunction
  task automatic ref_apply(input logic [2:0] op, input logic [1:0] rd_i, input logic [1:0] rs_i, input logic [7:0] d);
    logic [7:0] b;
    b = rs_i == 2'd0 ? 8'h00 : ref_r[rs_i];
    case (op)
      3'd0: ref_r[rd_i] = d;
      3'd1: ref_r[rd_i] = ref_r[0] ^ b;
      3'd2: ref_r[rd_i] = ref_r[0] & b;
      3'd3: ref_r[rd_i] = ref_r[0] << 1;
      3'd4: ref_r[rd_i] = b;
      default: ;
    endcase
  endtask
  task automatic run(input logic [2:0] op, input logic [1:0] rd_i, input logic [1:0] rs_i, input logic [7:0] d, input bit hold);
    bus.opcode = op;
    bus.rd = rd_i;
    bus.rs = rs_i;
    din = d;
    bus.start = 1'b1;
    lat = 0; nw = 0; nlt = 0; nbusy = 0; nerr = 0; oh_bad = 0;
    @(posedge clk);
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      else begin
        bus.opcode = 3'd0;
        bus.rd = ~rd_i;
      end
      t_sr[k] = bus.sr; t_tsel[k] = bus.tsel; t_bsel[k] = bus.bsel;
      t_alu[k] = bus.aluop; t_rn[k] = bus.Rn; t_w[k] = bus.w; t_lt[k] = bus.lt;
      nw += int'(bus.w);
      nlt += int'(bus.lt);
      nbusy += int'(bus.busy);
      nerr += int'(bus.err);
      if ($countones(bus.sr) > 1 || $countones(bus.tsel) > 1 || $countones(bus.bsel) > 1 || (bus.w && bus.done) || (bus.err && !bus.done)) oh_bad++;
      if (bus.done) lat = k;
    end
    bus.start = 1'b0;
    @(negedge clk);
    ref_apply(op, rd_i, rs_i, d);
  endtask
  task automatic verify(input string tag, input logic [2:0] op, input int elat, input int ew, input int eerr);
    check({tag, " latency"}, lat, elat);
    check({tag, " w pulses"}, nw, ew);
    check({tag, " err pulses"}, nerr, eerr);
    check({tag, " lt pulses"}, nlt, (op >= 3'd1 && op <= 3'd4) ? 1 : 0);
    check({tag, " busy cycles"}, nbusy, elat - 1);
    check({tag, " onehot/exclusive"}, oh_bad, 0);
    check({tag, " regs"}, {r_m[0], r_m[1], r_m[2], r_m[3]}, {ref_r[0], ref_r[1], ref_r[2], ref_r[3]});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ndone, nwr, nbz;
    logic [2:0] bor;
    bus.start = 1'b0; bus.opcode = '0; bus.rd = '0; bus.rs = '0; din = '0;
    tbl[0]  = '{3'd0, 2'd0, 2'd0, 8'hF0, 2, 1, 0, 8'hF0};
    tbl[1]  = '{3'd0, 2'd1, 2'd0, 8'h3C, 2, 1, 0, 8'h3C};
    tbl[2]  = '{3'd1, 2'd3, 2'd1, 8'h00, 4, 1, 0, 8'hCC};
    tbl[3]  = '{3'd0, 2'd0, 2'd0, 8'h81, 2, 1, 0, 8'h81};
    tbl[4]  = '{3'd3, 2'd0, 2'd2, 8'h00, 4, 1, 0, 8'h02};
    tbl[5]  = '{3'd0, 2'd3, 2'd0, 8'h77, 2, 1, 0, 8'h77};
    tbl[6]  = '{3'd4, 2'd1, 2'd3, 8'h00, 3, 1, 0, 8'h77};
    tbl[7]  = '{3'd0, 2'd2, 2'd0, 8'h5A, 2, 1, 0, 8'h5A};
    tbl[8]  = '{3'd2, 2'd2, 2'd1, 8'h00, 4, 1, 0, 8'h02};
    tbl[9]  = '{3'd4, 2'd0, 2'd0, 8'h00, 3, 1, 0, 8'h00};
    tbl[10] = '{3'd6, 2'd1, 2'd2, 8'h00, 1, 0, 1, 8'h77};
    repeat (2) @(negedge clk);
    check("reset outputs", {bus.sr, bus.Rn, bus.w, bus.aluop, bus.lt, bus.tsel, bus.bsel, bus.busy, bus.done, bus.err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle outputs", {bus.sr, bus.Rn, bus.w, bus.aluop, bus.lt, bus.tsel, bus.bsel, bus.busy, bus.done, bus.err}, 0);
    for (int i = 0; i < 11; i++) begin
      run(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].d, 1'b0);
      verify($sformatf("vec%0d", i), tbl[i].op, tbl[i].lat, tbl[i].nw, tbl[i].err);
      check($sformatf("vec%0d dest", i), r_m[tbl[i].rd], tbl[i].val);
    end
    run(3'd0, 2'd2, 2'd0, 8'h5A, 1'b0);
    check("ldi wb", {t_sr[1], t_w[1], t_rn[1]}, {3'b001, 1'b1, 2'd2});
    check("ldi r2", r_m[2], 8'h5A);
    run(3'd0, 2'd0, 2'd0, 8'hF0, 1'b0);
    run(3'd0, 2'd1, 2'd0, 8'h3C, 1'b0);
    run(3'd1, 2'd3, 2'd1, 8'h00, 1'b0);
    check("xor loadt", {t_lt[1], t_tsel[1], t_w[1]}, {1'b1, 3'b010, 1'b0});
    check("xor calc", {t_alu[2], t_bsel[2], t_w[2]}, {2'b00, 3'b001, 1'b0});
    check("xor wb", {t_sr[3], t_w[3], t_rn[3], t_bsel[3]}, {3'b010, 1'b1, 2'd3, 3'b001});
    check("xor latency", lat, 4);
    check("xor r3", r_m[3], 8'hCC);
    run(3'd0, 2'd0, 2'd0, 8'h81, 1'b0);
    run(3'd3, 2'd0, 2'd3, 8'h00, 1'b0);
    bor = '0;
    for (int k = 1; k <= lat; k++) bor |= t_bsel[k];
    check("shl bsel zero", bor, 3'b000);
    check("shl calc aluop", t_alu[2], 2'b10);
    check("shl w pulses", nw, 1);
    check("shl r0", r_m[0], 8'h02);
    run(3'd0, 2'd3, 2'd0, 8'h77, 1'b0);
    run(3'd4, 2'd1, 2'd3, 8'h00, 1'b0);
    check("mov loadt", {t_lt[1], t_tsel[1], t_bsel[1]}, {1'b1, 3'b100, 3'b100});
    check("mov wb", {t_sr[2], t_w[2], t_rn[2], t_lt[2]}, {3'b100, 1'b1, 2'd1, 1'b0});
    check("mov latency", lat, 3);
    check("mov r1", r_m[1], 8'h77);
    run(3'd6, 2'd0, 2'd1, 8'h00, 1'b0);
    verify("illegal", 3'd6, 1, 0, 1);
    run(3'd1, 2'd2, 2'd1, 8'h00, 1'b1);
    verify("busy start", 3'd1, 4, 1, 0);
    ndone = 0; nwr = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(bus.done);
      nwr += int'(bus.w);
    end
    check("busy start no 2nd done", ndone, 0);
    check("busy start no 2nd w", nwr, 0);
    bus.opcode = 3'd0; bus.rd = 2'd2; bus.rs = 2'd0; din = 8'h11; bus.start = 1'b1;
    ndone = 0; nwr = 0;
    repeat (9) begin
      @(negedge clk);
      ndone += int'(bus.done);
      nwr += int'(bus.w);
    end
    bus.start = 1'b0;
    @(negedge clk);
    ref_apply(3'd0, 2'd2, 2'd0, 8'h11);
    check("held start dones", ndone, 3);
    check("held start w", nwr, 3);
    check("held start r2", r_m[2], 8'h11);
    bus.opcode = 3'd1; bus.rd = 2'd3; bus.rs = 2'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {bus.sr, bus.Rn, bus.w, bus.aluop, bus.lt, bus.tsel, bus.bsel, bus.busy, bus.done, bus.err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0; nwr = 0; nbz = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(bus.done);
      nwr += int'(bus.w);
      nbz += int'(bus.busy);
    end
    check("abort done", ndone, 0);
    check("abort w", nwr, 0);
    check("abort busy", nbz, 0);
    check("abort regs", {r_m[0], r_m[1], r_m[2], r_m[3]}, {ref_r[0], ref_r[1], ref_r[2], ref_r[3]});
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
      verify($sformatf("rand%0d op%0d", i, op), op, exp_lat(op), op <= 3'd4 ? 1 : 0, op > 3'd4 ? 1 : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
